snoopy_sprite_drawer: RTL and testbench

- Consumer of the horizontal/vertical position FSM outputs (snoopy_x, snoopy_y).
- Once per frame_tick it erases Snoopy's sprite box at the previously drawn position with the background colour, then draws it at the newly sampled position with the foreground colour.
- Drives the 160x120 VGA adapter plot interface: one pixel per cycle on vga_x/vga_y/vga_colour/vga_plot.

---
 rtl/snoopy_pkg.sv | 17 +
 rtl/snoopy_sprite_drawer_if.sv | 23 ++
 rtl/snoopy_box_scanner.sv | 43 ++++
 rtl/snoopy_sprite_drawer.sv | 135 +++++++++++++
 tb/tb_snoopy_sprite_drawer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/snoopy_pkg.sv
// Shared types and defaults for the Snoopy sprite drawer and its box scanner.
package snoopy_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] DEFAULT_FG_COLOUR = 3'b110;
    localparam logic [2:0] DEFAULT_BG_COLOUR = 3'b000;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/snoopy_sprite_drawer_if.sv
// Pixel plot bus toward the 160x120 VGA adapter.
interface snoopy_sprite_drawer_if;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output vga_x,
        output vga_y,
        output vga_colour,
        output vga_plot
    );

    modport slave (
        input vga_x,
        input vga_y,
        input vga_colour,
        input vga_plot
    );

endinterface

// File: rtl/snoopy_box_scanner.sv
// Row-major dx/dy walker over a SPRITE_W x SPRITE_H box; last flags the final pixel.
module snoopy_box_scanner #(
    parameter int unsigned SPRITE_W = 5,
    parameter int unsigned SPRITE_H = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       active,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);

    localparam logic [3:0] DX_MAX = 4'(SPRITE_W - 1);
    localparam logic [3:0] DY_MAX = 4'(SPRITE_H - 1);

    logic [3:0] dx_q;
    logic [3:0] dy_q;

    assign dx   = dx_q;
    assign dy   = dy_q;
    assign last = active && (dx_q == DX_MAX) && (dy_q == DY_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            dx_q <= 4'd0;
            dy_q <= 4'd0;
        end else if (start) begin
            dx_q <= 4'd0;
            dy_q <= 4'd0;
        end else if (active) begin
            if (dx_q == DX_MAX) begin
                dx_q <= 4'd0;
                // Wrapping dy on the last pixel leaves the walker ready for the next phase.
                dy_q <= (dy_q == DY_MAX) ? 4'd0 : dy_q + 4'd1;
            end else begin
                dx_q <= dx_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/snoopy_sprite_drawer.sv
// Per frame_tick: erase the sprite box at the old position, then draw it at the new one.
module snoopy_sprite_drawer #(
    parameter int unsigned SPRITE_W  = 5,
    parameter int unsigned SPRITE_H  = 5,
    parameter int unsigned SCREEN_W  = snoopy_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H  = snoopy_pkg::SCREEN_H,
    parameter logic [2:0]  FG_COLOUR = snoopy_pkg::DEFAULT_FG_COLOUR,
    parameter logic [2:0]  BG_COLOUR = snoopy_pkg::DEFAULT_BG_COLOUR
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [7:0]                    snoopy_x,
    input  logic [6:0]                    snoopy_y,
    snoopy_sprite_drawer_if.master        vga,
    output logic                          busy,
    output logic                          done
);

    import snoopy_pkg::*;

    state_t     state;
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic       prev_valid;

    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] vga_colour_q;
    logic       vga_plot_q;
    logic       busy_q;
    logic       done_q;

    logic       scan_start;
    logic       scan_active;
    logic [3:0] dx;
    logic [3:0] dy;
    logic       scan_last;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       in_view;

    assign scan_start  = (state == S_IDLE) && frame_tick;
    assign scan_active = (state == S_ERASE) || (state == S_DRAW);

    snoopy_box_scanner #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scanner (
        .clock  (clock),
        .reset  (reset),
        .start  (scan_start),
        .active (scan_active),
        .dx     (dx),
        .dy     (dy),
        .last   (scan_last)
    );

    always_comb begin
        base_x  = (state == S_ERASE) ? prev_x : cur_x;
        base_y  = (state == S_ERASE) ? prev_y : cur_y;
        sum_x   = {1'b0, base_x} + {5'b0, dx};
        sum_y   = {1'b0, base_y} + {4'b0, dy};
        in_view = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            cur_x        <= 8'd0;
            cur_y        <= 7'd0;
            prev_x       <= 8'd0;
            prev_y       <= 7'd0;
            prev_valid   <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            vga_plot_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (frame_tick) begin
                        cur_x  <= snoopy_x;
                        cur_y  <= snoopy_y;
                        busy_q <= 1'b1;
                        if (!prev_valid) begin
                            state <= S_DRAW;
                        end else if ((snoopy_x != prev_x) || (snoopy_y != prev_y)) begin
                            state <= S_ERASE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ERASE, S_DRAW: begin
                    // Clipped slots still take their cycle so latency never depends on position.
                    vga_x_q      <= sum_x[7:0];
                    vga_y_q      <= sum_y[6:0];
                    vga_colour_q <= (state == S_ERASE) ? BG_COLOUR : FG_COLOUR;
                    vga_plot_q   <= in_view;
                    busy_q       <= 1'b1;
                    if (scan_last) begin
                        state <= (state == S_ERASE) ? S_DRAW : S_DONE;
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    prev_x     <= cur_x;
                    prev_y     <= cur_y;
                    prev_valid <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign vga.vga_x      = vga_x_q;
    assign vga.vga_y      = vga_y_q;
    assign vga.vga_colour = vga_colour_q;
    assign vga.vga_plot   = vga_plot_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Scoreboard bench: expected plots are queued per redraw and popped as the DUT plots them.
module tb_snoopy_sprite_drawer;

    localparam int SW = 5;
    localparam int SH = 5;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] snoopy_x = 8'd0;
    logic [6:0] snoopy_y = 7'd0;
    logic       busy;
    logic       done;

    snoopy_sprite_drawer_if vga ();

    snoopy_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .snoopy_x   (snoopy_x),
        .snoopy_y   (snoopy_y),
        .vga        (vga),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int plot_count = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue the in-view pixels of a box in row-major order, at most limit of them.
    task automatic push_box(input int x, input int y, input logic [2:0] colour, input int limit);
        int n = 0;
        for (int dy = 0; dy < SH; dy++) begin
            for (int dx = 0; dx < SW; dx++) begin
                if (n < limit && (x + dx) < SCR_W && (y + dy) < SCR_H) begin
                    exp_q.push_back({8'(x + dx), 7'(y + dy), colour});
                end
                n++;
            end
        end
    endtask

    always @(negedge clock) begin
        if (vga.vga_plot === 1'b1) begin
            plot_count++;
            if (exp_q.size() == 0) begin
                check("plot_unexpected", 1, 0);
            end else begin
                check("pixel", {vga.vga_x, vga.vga_y, vga.vga_colour}, exp_q.pop_front());
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic redraw(input string tag, input int exp_lat, input int exp_plots,
                          input int inject_at);
        int start_plots;
        int lat = 0;
        int busy_cycles = 0;
        int dones = 0;
        start_plots = plot_count;
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == inject_at) begin
                frame_tick = 1'b1;
                snoopy_x   = snoopy_x + 8'd50;
            end else begin
                frame_tick = 1'b0;
            end
            @(negedge clock);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                dones++;
                if (lat == 0) lat = cyc;
            end
            if (lat != 0 && cyc >= lat + 60) break;
        end
        frame_tick = 1'b0;
        check({tag, "_done_latency"}, lat, exp_lat);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_busy_cycles"}, busy_cycles, exp_lat);
        check({tag, "_plot_count"}, plot_count - start_plots, exp_plots);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_plot", vga.vga_plot, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_x", vga.vga_x, 0);
        check("reset_y", vga.vga_y, 0);
        check("reset_colour", vga.vga_colour, 0);
        reset = 1'b1;

        snoopy_x = 8'd15;
        snoopy_y = 7'd100;
        push_box(15, 100, 3'b110, 25);
        redraw("first", 26, 25, 0);

        snoopy_x = 8'd16;
        push_box(15, 100, 3'b000, 25);
        push_box(16, 100, 3'b110, 25);
        redraw("move", 51, 50, 0);

        redraw("same", 1, 0, 0);

        pulse_reset();
        snoopy_x = 8'd157;
        snoopy_y = 7'd117;
        push_box(157, 117, 3'b110, 25);
        redraw("clip", 26, 9, 0);

        snoopy_x = 8'd40;
        snoopy_y = 7'd50;
        push_box(157, 117, 3'b000, 25);
        push_box(40, 50, 3'b110, 25);
        redraw("overlap", 51, 34, 30);

        // Abort an erase after its first 10 pixels.
        snoopy_x = 8'd60;
        snoopy_y = 7'd20;
        push_box(40, 50, 3'b000, 10);
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_plot", vga.vga_plot, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_queue", exp_q.size(), 0);
        reset = 1'b1;

        snoopy_x = 8'd70;
        snoopy_y = 7'd30;
        push_box(70, 30, 3'b110, 25);
        redraw("post_reset", 26, 25, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
